// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundle between the byte-stream requesters, the UART arbiter and the byte
//   serializer.
//   master : stream sources + serializer side (drives req*, tx_ready)
//   slave  : the arbiter (drives req_ack, grant, tx_*, busy, timeout_err,
//            pkt_count)
//   req[i], req_valid[i], req_last[i], req_data[8i+7:8i] : requester i byte stream
//   req_ack   : one-cycle "byte consumed" pulse per requester
//   grant     : one-hot current owner, zero when idle
//   tx_ready  : serializer can take a byte
//   tx_start  : one-cycle load strobe for tx_data
//   busy, timeout_err, pkt_count : status
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 16
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ack;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 busy;
    logic                 timeout_err;
    logic [CNT_W-1:0]     pkt_count;

    modport master (
        output req, req_valid, req_last, req_data, tx_ready,
        input  req_ack, grant, tx_start, tx_data, busy, timeout_err, pkt_count
    );

    modport slave (
        input  req, req_valid, req_last, req_data, tx_ready,
        output req_ack, grant, tx_start, tx_data, busy, timeout_err, pkt_count
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmit serializer between NUM_REQ byte-stream requesters.
//   Ownership is granted per packet, round-robin, and a watchdog revokes the
//   grant from an owner that stops presenting bytes.
//   Ports:
//     clk   : UART-domain clock, rising edge
//     rst_n : synchronous active-low reset
//     bus   : uart_tx_arbiter_if.slave (request streams, serializer, status)
//   Build option:
//     UART_ARB_HEADER_EN : when defined, every packet is preceded by a header
//                          byte 8'hA0 | owner index (no req_ack for it).
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no owner; pick next requester after the last granted index
//   GRANT | owner holds the transmitter, waiting for tx_ready && req_valid
//   SEND  | byte launched; skip one cycle, then wait for tx_ready
//   HDR   | (header build only) first state of a grant, sends the header byte
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input logic              clk,
    input logic              rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef UART_ARB_HEADER_EN
    typedef enum logic [1:0] {IDLE, GRANT, SEND, HDR} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT, SEND} state_t;
`endif

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               last_q, last_d;
    logic               first_q, first_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic               timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;

    logic               found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand_idx;
    int                 cand;
    logic               own_req;
    logic               own_valid;
    logic               own_last;
    logic [7:0]         own_data;
    logic [TMO_W-1:0]   tmo_inc;
    logic               tmo_hit;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        last_d        = last_q;
        first_d       = first_q;
        tmo_cnt_d     = tmo_cnt_q;
        grant_d       = grant_q;
        req_ack_d     = '0;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        busy_d        = busy_q;
        timeout_err_d = 1'b0;
        pkt_count_d   = pkt_count_q;

        // Round-robin search starts one past the last granted index.
        found    = 1'b0;
        pick_idx = ptr_q;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand     = (int'(ptr_q) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && bus.req[cand_idx]) begin
                found    = 1'b1;
                pick_idx = cand_idx;
            end
        end

        own_req   = bus.req[owner_q];
        own_valid = bus.req_valid[owner_q];
        own_last  = bus.req_last[owner_q];
        own_data  = 8'(bus.req_data >> {owner_q, 3'b000});
        tmo_inc   = tmo_cnt_q + 1'b1;
        tmo_hit   = (tmo_inc == TMO_W'(TIMEOUT_CYCLES));

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d   = NUM_REQ'(1) << pick_idx;
                    busy_d    = 1'b1;
                    owner_d   = pick_idx;
                    ptr_d     = pick_idx;
                    tmo_cnt_d = '0;
`ifdef UART_ARB_HEADER_EN
                    state_d   = HDR;
`else
                    state_d   = GRANT;
`endif
                end
            end
            GRANT: begin
                if (bus.tx_ready && own_valid) begin
                    tx_start_d         = 1'b1;
                    req_ack_d[owner_q] = 1'b1;
                    tx_data_d          = own_data;
                    last_d             = own_last;
                    first_d            = 1'b1;
                    tmo_cnt_d          = '0;
                    state_d            = SEND;
                end else if (!own_req && !own_valid) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (!own_valid) begin
                    // tx_ready stalls with a valid byte do not count as idle
                    tmo_cnt_d = tmo_inc;
                    if (tmo_hit) begin
                        timeout_err_d = 1'b1;
                        grant_d       = '0;
                        busy_d        = 1'b0;
                        state_d       = IDLE;
                    end
                end
            end
`ifdef UART_ARB_HEADER_EN
            HDR: begin
                // An abort or timeout here releases without ever sending the header.
                if (!own_req && !own_valid) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (bus.tx_ready) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = 8'hA0 | 8'(owner_q);
                    last_d     = 1'b0;
                    first_d    = 1'b1;
                    tmo_cnt_d  = '0;
                    state_d    = SEND;
                end else if (!own_valid) begin
                    tmo_cnt_d = tmo_inc;
                    if (tmo_hit) begin
                        timeout_err_d = 1'b1;
                        grant_d       = '0;
                        busy_d        = 1'b0;
                        state_d       = IDLE;
                    end
                end
            end
`endif
            SEND: begin
                // The serializer only drops tx_ready during the cycle after
                // tx_start, so that cycle's tx_ready is stale.
                if (first_q) begin
                    first_d = 1'b0;
                end else if (bus.tx_ready) begin
                    if (last_q) begin
                        pkt_count_d = pkt_count_q + 1'b1;
                        grant_d     = '0;
                        busy_d      = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        state_d = GRANT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            ptr_q         <= IDX_W'(NUM_REQ - 1);
            last_q        <= 1'b0;
            first_q       <= 1'b0;
            tmo_cnt_q     <= '0;
            grant_q       <= '0;
            req_ack_q     <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            pkt_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            last_q        <= last_d;
            first_q       <= first_d;
            tmo_cnt_q     <= tmo_cnt_d;
            grant_q       <= grant_d;
            req_ack_q     <= req_ack_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            pkt_count_q   <= pkt_count_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.req_ack     = req_ack_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.pkt_count   = pkt_count_q;
endmodule
